// File: rtl/bp_stall_profiler_pkg.sv
// Shared definitions for the stall-profiling counter sampler: FSM states, header layout,
// and the counter index map that host software uses to decode snapshot packets.
package bp_stall_profiler_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_hdr,
    e_body
  } sampler_state_e;

  // Header word carries only the snapshot sequence number today.
  typedef struct packed {
    logic [31:0] seq;
  } sampler_hdr_s;

  localparam int unsigned num_cnt_c = 34;

  // Word position of each counter within a snapshot packet body.
  typedef enum logic [5:0] {
    e_cnt_mcycle               = 6'd0,
    e_cnt_minstret             = 6'd1,
    e_cnt_stall_fe_queue       = 6'd2,
    e_cnt_stall_icache_miss    = 6'd3,
    e_cnt_stall_itlb_miss      = 6'd4,
    e_cnt_stall_branch_mispred = 6'd5,
    e_cnt_stall_control_haz    = 6'd6,
    e_cnt_stall_long_haz       = 6'd7,
    e_cnt_stall_data_haz       = 6'd8,
    e_cnt_stall_aux_dep        = 6'd9,
    e_cnt_stall_load_dep       = 6'd10,
    e_cnt_stall_mul_dep        = 6'd11,
    e_cnt_stall_fma_dep        = 6'd12,
    e_cnt_stall_sb_iraw        = 6'd13,
    e_cnt_stall_sb_fraw        = 6'd14,
    e_cnt_stall_sb_iwaw        = 6'd15,
    e_cnt_stall_sb_fwaw        = 6'd16,
    e_cnt_stall_struct_haz     = 6'd17,
    e_cnt_stall_idiv_haz       = 6'd18,
    e_cnt_stall_fdiv_haz       = 6'd19,
    e_cnt_stall_ptw_busy       = 6'd20,
    e_cnt_stall_special        = 6'd21,
    e_cnt_stall_replay         = 6'd22,
    e_cnt_stall_exception      = 6'd23,
    e_cnt_stall_dcache_miss    = 6'd24,
    e_cnt_stall_dtlb_miss      = 6'd25,
    e_cnt_stall_unknown        = 6'd26,
    e_cnt_instr_int            = 6'd27,
    e_cnt_instr_load           = 6'd28,
    e_cnt_instr_store          = 6'd29,
    e_cnt_instr_branch         = 6'd30,
    e_cnt_instr_jump           = 6'd31,
    e_cnt_instr_fp             = 6'd32,
    e_cnt_instr_csr            = 6'd33
  } cnt_idx_e;

endpackage

// File: rtl/bp_stall_sample_timer.sv
// Periodic sample tick generator: fires once every interval_i cycles while the core runs.
module bp_stall_sample_timer #(
  parameter int unsigned interval_w_p = 24
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    freeze_i,
  input  logic [interval_w_p-1:0] interval_i,
  output logic                    tick_o
);

  logic [interval_w_p-1:0] timer_q, timer_d;
  logic                    active;

  assign active = ~freeze_i & (interval_i != '0);

  // >= rather than == so a shrunk interval still fires and wraps on the next compare.
  assign tick_o = active & (timer_q >= (interval_i - interval_w_p'(1)));

  always_comb begin
    timer_d = timer_q;
    if (!active || tick_o) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + interval_w_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/bp_stall_counter_sampler.sv
// Atomically snapshots the profiling counter bank on a periodic tick or host trigger and
// streams each snapshot as a valid/ready packet: one header word, then one word per counter.
module bp_stall_counter_sampler
  import bp_stall_profiler_pkg::*;
#(
  parameter int unsigned width_p        = 32,
  parameter int unsigned num_counters_p = 34,
  parameter int unsigned interval_w_p   = 24
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              freeze_i,
  input  logic [num_counters_p*width_p-1:0] counters_i,
  input  logic [interval_w_p-1:0]           interval_i,
  input  logic                              trigger_i,
  output logic [width_p-1:0]                data_o,
  output logic                              v_o,
  output logic                              last_o,
  input  logic                              ready_i,
  output logic                              busy_o,
  output logic [width_p-1:0]                dropped_o
);

  localparam int unsigned idx_w_lp = (num_counters_p > 1) ? $clog2(num_counters_p) : 1;
  typedef logic [idx_w_lp-1:0] idx_t;
  localparam idx_t last_idx_lp = idx_t'(num_counters_p - 1);

  sampler_state_e     state_q, state_d;
  idx_t               idx_q, idx_d, idx_nxt;
  logic [width_p-1:0] seq_q, seq_d;
  logic [width_p-1:0] data_q, data_d;
  logic [width_p-1:0] dropped_q, dropped_d;
  logic               v_q, v_d;
  logic               last_q, last_d;
  logic [width_p-1:0] snap_q [num_counters_p];
  logic [width_p-1:0] snap_d [num_counters_p];

  logic tick, req;

  bp_stall_sample_timer #(
    .interval_w_p(interval_w_p)
  ) u_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .freeze_i  (freeze_i),
    .interval_i(interval_i),
    .tick_o    (tick)
  );

  assign req     = (tick | trigger_i) & ~freeze_i;
  assign idx_nxt = idx_q + idx_t'(1);

  // Output registers are loaded with the word that will be presented in the next state,
  // so data_o/v_o/last_o come straight from flops and hold while stalled.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    data_d    = data_q;
    dropped_d = dropped_q;
    v_d       = v_q;
    last_d    = last_q;
    snap_d    = snap_q;

    unique case (state_q)
      e_idle: begin
        if (req) begin
          for (int unsigned k = 0; k < num_counters_p; k++) begin
            snap_d[k] = counters_i[k*width_p +: width_p];
          end
          seq_d   = seq_q + width_p'(1);
          data_d  = seq_q;
          v_d     = 1'b1;
          last_d  = 1'b0;
          state_d = e_hdr;
        end
      end
      e_hdr: begin
        if (ready_i) begin
          idx_d   = '0;
          data_d  = snap_q[0];
          last_d  = (last_idx_lp == '0);
          state_d = e_body;
        end
      end
      e_body: begin
        if (ready_i) begin
          if (idx_q == last_idx_lp) begin
            data_d  = '0;
            v_d     = 1'b0;
            last_d  = 1'b0;
            state_d = e_idle;
          end else begin
            idx_d  = idx_nxt;
            data_d = snap_q[idx_nxt];
            last_d = (idx_nxt == last_idx_lp);
          end
        end
      end
      default: begin
        state_d = e_idle;
        v_d     = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    if (req && (state_q != e_idle) && (dropped_q != '1)) begin
      dropped_d = dropped_q + width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= e_idle;
      idx_q     <= '0;
      seq_q     <= '0;
      data_q    <= '0;
      dropped_q <= '0;
      v_q       <= 1'b0;
      last_q    <= 1'b0;
      for (int unsigned k = 0; k < num_counters_p; k++) begin
        snap_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      data_q    <= data_d;
      dropped_q <= dropped_d;
      v_q       <= v_d;
      last_q    <= last_d;
      snap_q    <= snap_d;
    end
  end

  assign data_o    = data_q;
  assign v_o       = v_q;
  assign last_o    = last_q;
  assign busy_o    = (state_q != e_idle);
  assign dropped_o = dropped_q;

endmodule

// File: tb/tb_bp_stall_counter_sampler.sv
// Directed-plus-random bench for the counter sampler, checked against a packet-queue model.
module tb_bp_stall_counter_sampler;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 34;
  localparam int unsigned IW = 24;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            freeze = 1'b0;
  logic [N*W-1:0]  counters = '0;
  logic [IW-1:0]   interval = '0;
  logic            trig = 1'b0;
  logic            ready = 1'b0;
  logic [W-1:0]    data_o;
  logic            v_o;
  logic            last_o;
  logic            busy_o;
  logic [W-1:0]    dropped_o;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference model: expected stream words still to be delivered, plus sampling state.
  logic [W-1:0] q[$];
  logic [W-1:0] mseq = '0;
  logic [W-1:0] mdrop = '0;
  int unsigned  mt = 0;
  bit           cnt_inc = 1'b1;
  bit           rand_ready = 1'b0;
  bit           rand_trig = 1'b0;

  bp_stall_counter_sampler #(
    .width_p       (W),
    .num_counters_p(N),
    .interval_w_p  (IW)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .freeze_i  (freeze),
    .counters_i(counters),
    .interval_i(interval),
    .trigger_i (trig),
    .data_o    (data_o),
    .v_o       (v_o),
    .last_o    (last_o),
    .ready_i   (ready),
    .busy_o    (busy_o),
    .dropped_o (dropped_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mseq  = '0;
    mdrop = '0;
    mt    = 0;
  endtask

  task automatic new_counters();
    for (int k = 0; k < N; k++) begin
      if (cnt_inc) counters[k*W +: W] = counters[k*W +: W] + 32'd1;
      else         counters[k*W +: W] = $urandom;
    end
  endtask

  // One clock: predict from the inputs the DUT is about to see, clock, then compare.
  task automatic step();
    bit active, tick, req, busy, acc;
    if (rand_ready) ready = ($urandom_range(0, 1) == 1);
    if (rand_trig)  trig  = ($urandom_range(0, 19) == 0);
    active = !freeze && (interval != 0);
    tick   = active && (mt + 1 >= int'(interval));
    req    = (tick || trig) && !freeze;
    busy   = (q.size() != 0);
    acc    = busy && ready;
    if (acc) void'(q.pop_front());
    if (req) begin
      if (busy) begin
        if (mdrop != 32'hffff_ffff) mdrop = mdrop + 32'd1;
      end else begin
        q.push_back(mseq);
        mseq = mseq + 32'd1;
        for (int k = 0; k < N; k++) q.push_back(counters[k*W +: W]);
      end
    end
    mt = active ? (tick ? 0 : mt + 1) : 0;
    @(posedge clk);
    @(negedge clk);
    chk("v_o", {31'd0, v_o}, {31'd0, q.size() != 0});
    chk("busy_o", {31'd0, busy_o}, {31'd0, q.size() != 0});
    chk("dropped_o", dropped_o, mdrop);
    if (q.size() != 0) begin
      chk("data_o", data_o, q[0]);
      chk("last_o", {31'd0, last_o}, {31'd0, q.size() == 1});
    end else begin
      chk("last_o_idle", {31'd0, last_o}, 32'd0);
    end
    new_counters();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_v", {31'd0, v_o}, 32'd0);
    chk("rst_last", {31'd0, last_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_dropped", dropped_o, 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit found;
    logic [W-1:0] saved;

    // 1: periodic sampling, full-rate sink
    interval = 24'd100;
    ready    = 1'b1;
    do_reset();
    repeat (320) step();

    // 2: incrementing counters, 50% backpressure, sparse random triggers
    rand_ready = 1'b1;
    interval   = 24'd60;
    repeat (200) step();
    rand_trig = 1'b1;
    cnt_inc   = 1'b0;
    repeat (200) step();
    rand_trig  = 1'b0;
    rand_ready = 1'b0;
    trig       = 1'b0;
    cnt_inc    = 1'b1;
    ready      = 1'b1;

    // interval shrunk below the running timer value: must fire and wrap next compare
    interval = 24'd200;
    repeat (80) step();
    interval = 24'd30;
    repeat (100) step();

    // 3: periodic off, single trigger -> one packet
    interval = '0;
    repeat (40) step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (60) step();

    // trigger coincident with tick -> one packet, nothing dropped
    interval = 24'd50;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0 && mt + 1 >= int'(interval)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("align_tick_found", {31'd0, found}, 32'd1);
    saved = dropped_o;
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (40) step();
    chk("coincident_no_drop", dropped_o, saved);

    // 4: stalled sink for 500 cycles
    ready    = 1'b0;
    interval = 24'd100;
    do_reset();
    repeat (500) step();
    chk("stall_dropped", dropped_o, 32'd4);
    chk("stall_hdr_seq", data_o, 32'd0);
    ready = 1'b1;
    repeat (60) step();

    // 5: freeze at body word 10
    interval = '0;
    trig = 1'b1;
    step();
    trig = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (q.size() == N - 10) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("freeze_reach_word10", {31'd0, found}, 32'd1);
    freeze   = 1'b1;
    interval = 24'd100;
    rand_trig = 1'b1;
    repeat (80) step();
    rand_trig = 1'b0;
    trig      = 1'b0;
    chk("frozen_idle", {31'd0, v_o}, 32'd0);
    freeze = 1'b0;
    repeat (250) step();

    // 6: reset mid-body, then fresh packet starts at seq 0
    interval = '0;
    cnt_inc  = 1'b0;
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (15) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_v", {31'd0, v_o}, 32'd0);
    chk("async_rst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("post_rst_seq", data_o, 32'd0);
    repeat (50) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
